// File: rtl/stream_pool2d.sv
// Streaming POOLxPOOL max/average pooling over a raster-order pixel stream.
// A line accumulator of OW entries per channel holds the partial window results
// of the current band of POOL rows, so only one output row is ever buffered.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   mode                   0 = max, 1 = average; taken on the first beat of a frame
//   in_valid/in_ready      input handshake, in_data = CHANNELS packed samples
//   out_valid/out_ready    output handshake, out_data = pooled pixel, same packing
//   frame_done             pulses combinationally with the last accepted beat of a frame
module stream_pool2d #(
  parameter int unsigned IMG_W     = 62,
  parameter int unsigned IMG_H     = 65,
  parameter int unsigned CHANNELS  = 32,
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned POOL      = 2,
  parameter int unsigned SIGNED    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*BIT_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*BIT_WIDTH-1:0] out_data,
  output logic                          frame_done
);

  localparam int unsigned DW    = CHANNELS * BIT_WIDTH;
  localparam int unsigned LOG2P = (POOL == 4) ? 2 : 1;
  localparam int unsigned SH    = 2 * LOG2P;
  localparam int unsigned ACC_W = BIT_WIDTH + SH;
  localparam int unsigned OW    = IMG_W / POOL;
  localparam int unsigned OH    = IMG_H / POOL;
  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned AD    = (OW > 0) ? OW : 1;
  localparam int unsigned AW    = (AD > 1) ? $clog2(AD) : 1;
  localparam int unsigned LW    = CHANNELS * ACC_W;

  localparam logic [LOG2P-1:0] PH_LAST = LOG2P'(POOL - 1);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             mode_q;
  logic             rdy_q;
  logic [LW-1:0]    acc_mem [AD];
  logic [AD-1:0]    acc_vld;

  logic             accept;
  logic             frame_start;
  logic             last_beat;
  logic             in_region;
  logic             win_first;
  logic             win_last;
  logic             mode_eff;
  logic [AW-1:0]    acc_idx;
  logic [LW-1:0]    acc_old;
  logic [LW-1:0]    acc_new;
  logic [DW-1:0]    result;
  logic [LOG2P-1:0] col_ph;
  logic [LOG2P-1:0] row_ph;

  // Sample widened to the accumulator, sign- or zero-extended.
  function automatic logic [ACC_W-1:0] widen(input logic [BIT_WIDTH-1:0] s);
    if (SIGNED != 0) return {{SH{s[BIT_WIDTH-1]}}, s};
    else             return {{SH{1'b0}}, s};
  endfunction

  function automatic logic greater(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  // Final output value: low bits of the max, or the floored window mean.
  function automatic logic [BIT_WIDTH-1:0] finish_val(input logic avg, input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] sh;
    if (SIGNED != 0) sh = $signed(v) >>> SH;
    else             sh = v >> SH;
    return avg ? sh[BIT_WIDTH-1:0] : v[BIT_WIDTH-1:0];
  endfunction

  // Position decode for the current beat.
  always_comb begin
    accept      = in_valid && in_ready;
    frame_start = (col_q == '0) && (row_q == '0);
    last_beat   = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
    in_region   = (32'(col_q) < OW * POOL) && (32'(row_q) < OH * POOL);
    col_ph      = col_q[LOG2P-1:0];
    row_ph      = row_q[LOG2P-1:0];
    acc_idx     = AW'(col_q >> LOG2P);
    win_last    = (col_ph == PH_LAST) && (row_ph == PH_LAST);
    // An entry never written since reset is treated as a window start.
    win_first   = ((col_ph == '0) && (row_ph == '0)) || !acc_vld[acc_idx];
    mode_eff    = frame_start ? mode : mode_q;
    in_ready    = rdy_q && (!out_valid || out_ready);
    frame_done  = accept && last_beat;
  end

  // Per-channel combine of the incoming sample with the stored partial result.
  always_comb begin
    acc_old = acc_mem[acc_idx];
    acc_new = '0;
    result  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (win_first)
        acc_new[c*ACC_W +: ACC_W] = widen(in_data[c*BIT_WIDTH +: BIT_WIDTH]);
      else if (mode_eff)
        acc_new[c*ACC_W +: ACC_W] = acc_old[c*ACC_W +: ACC_W] + widen(in_data[c*BIT_WIDTH +: BIT_WIDTH]);
      else if (greater(widen(in_data[c*BIT_WIDTH +: BIT_WIDTH]), acc_old[c*ACC_W +: ACC_W]))
        acc_new[c*ACC_W +: ACC_W] = widen(in_data[c*BIT_WIDTH +: BIT_WIDTH]);
      else
        acc_new[c*ACC_W +: ACC_W] = acc_old[c*ACC_W +: ACC_W];
      result[c*BIT_WIDTH +: BIT_WIDTH] = finish_val(mode_eff, acc_new[c*ACC_W +: ACC_W]);
    end
  end

  // Line accumulator storage; contents are meaningless until acc_vld marks them.
  always_ff @(posedge clk) begin
    if (accept && in_region) acc_mem[acc_idx] <= acc_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   acc_vld <= '0;
    else if (accept && in_region) acc_vld[acc_idx] <= 1'b1;
  end

  // Raster position counters and per-frame mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (frame_start) mode_q <= mode;
      if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Input side opens one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Single-entry output register; a new result may load while the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && in_region && win_last) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2d.sv
module tb_stream_pool2d;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        out_ready;
  logic [31:0] in_data;
  logic        sel;

  logic        in_valid_a, in_ready_a, out_valid_a, frame_done_a;
  logic [31:0] out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, frame_done_b;
  logic [31:0] out_data_b;

  logic        obs_ir, obs_ov, obs_fd;
  logic [31:0] obs_od;

  int errors = 0;
  int checks = 0;

  logic [15:0] pix0 [25];
  logic [15:0] pix1 [25];
  logic [15:0] e0   [25];
  logic [15:0] e1   [25];
  logic        ev   [25];

  always #5 clk = ~clk;

  // 4x4 frame, signed data
  stream_pool2d #(.IMG_W(4), .IMG_H(4), .CHANNELS(2), .BIT_WIDTH(16), .POOL(2), .SIGNED(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .frame_done(frame_done_a)
  );

  // 5x5 frame, unsigned data, ragged edge
  stream_pool2d #(.IMG_W(5), .IMG_H(5), .CHANNELS(2), .BIT_WIDTH(16), .POOL(2), .SIGNED(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .frame_done(frame_done_b)
  );

  assign obs_ir = sel ? in_ready_b   : in_ready_a;
  assign obs_ov = sel ? out_valid_b  : out_valid_a;
  assign obs_fd = sel ? frame_done_b : frame_done_a;
  assign obs_od = sel ? out_data_b   : out_data_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 25; k++) begin
      ev[k] = 1'b0; e0[k] = '0; e1[k] = '0;
    end
  endtask

  task automatic set_exp(input int k, input logic [15:0] v0, input logic [15:0] v1);
    ev[k] = 1'b1; e0[k] = v0; e1[k] = v1;
  endtask

  task automatic load_4x4();
    for (int k = 0; k < 16; k++) begin
      pix0[k] = 16'(k);
      pix1[k] = 16'(-k);
    end
    pix1[0] = 16'(-3); pix1[1] = 16'(-1); pix1[4] = 16'(-8); pix1[5] = 16'(-2);
  endtask

  task automatic exp_4x4_max();
    clear_exp();
    set_exp(5,  16'd5,  16'hFFFF);
    set_exp(7,  16'd7,  16'hFFFE);
    set_exp(13, 16'd13, 16'hFFF8);
    set_exp(15, 16'd15, 16'hFFF6);
  endtask

  // Drives beat k of an n-beat frame (entered just after a clock edge) and checks
  // the handshake, frame_done and the registered output one cycle later.
  task automatic send(input int k, input int n);
    in_data = {pix1[k], pix0[k]};
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    #1;
    chk($sformatf("in_ready[%0d]", k), 32'(obs_ir), 32'(1));
    chk($sformatf("frame_done[%0d]", k), 32'(obs_fd), 32'(k == n - 1));
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    chk($sformatf("out_valid[%0d]", k), 32'(obs_ov), 32'(ev[k]));
    if (ev[k]) chk($sformatf("out_data[%0d]", k), obs_od, {e1[k], e0[k]});
  endtask

  initial begin
    rst_n      = 1'b0;
    mode       = 1'b0;
    out_ready  = 1'b1;
    in_data    = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    sel        = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(obs_ov), 32'(0));
    chk("rst_out_data", obs_od, 32'h0);
    chk("rst_frame_done", 32'(obs_fd), 32'(0));
    chk("rst_in_ready", 32'(obs_ir), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_at_release", 32'(obs_ir), 32'(0));
    @(posedge clk); #1;
    chk("in_ready_after_release", 32'(obs_ir), 32'(1));

    // 4x4 max frame
    load_4x4();
    exp_4x4_max();
    mode = 1'b0;
    for (int k = 0; k < 16; k++) send(k, 16);

    // 4x4 average frame; mode flips back after the first beat and must be ignored
    clear_exp();
    set_exp(5,  16'd2,  16'hFFFC);
    set_exp(7,  16'd4,  16'hFFFB);
    set_exp(13, 16'd10, 16'hFFF5);
    set_exp(15, 16'd12, 16'hFFF3);
    mode = 1'b1;
    send(0, 16);
    mode = 1'b0;
    for (int k = 1; k < 16; k++) send(k, 16);

    // Max frame with a 5-cycle output stall after the first result
    exp_4x4_max();
    for (int k = 0; k < 6; k++) send(k, 16);
    out_ready  = 1'b0;
    in_data    = {pix1[6], pix0[6]};
    in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_in_ready[%0d]", i), 32'(obs_ir), 32'(0));
      chk($sformatf("stall_out_valid[%0d]", i), 32'(obs_ov), 32'(1));
      chk($sformatf("stall_out_data[%0d]", i), obs_od, {16'hFFFF, 16'd5});
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    out_ready  = 1'b1;
    for (int k = 6; k < 16; k++) send(k, 16);

    // Reset in the middle of a frame with a result pending
    for (int k = 0; k < 6; k++) send(k, 16);
    mode  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(obs_ov), 32'(0));
    chk("midrst_in_ready", 32'(obs_ir), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) send(k, 16);

    // 5x5 unsigned max frame: last column and row are dropped; one idle gap
    sel = 1'b1;
    for (int k = 0; k < 25; k++) begin
      pix0[k] = 16'(k);
      pix1[k] = 16'(100 + k);
    end
    clear_exp();
    set_exp(6,  16'd6,  16'd106);
    set_exp(8,  16'd8,  16'd108);
    set_exp(16, 16'd16, 16'd116);
    set_exp(18, 16'd18, 16'd118);
    for (int k = 0; k < 12; k++) send(k, 25);
    @(posedge clk); #1;
    for (int k = 12; k < 25; k++) send(k, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_pool2d.md
Name: stream_pool2d

Overview:
- Streaming 2D pooling stage for the CNN pipeline. Replaces the full-frame-array pooling block that sits between conv layers.
- Consumes one pixel per beat, in raster order, with all channels packed. Emits one pooled pixel per completed POOLxPOOL window, with valid/ready on both sides.
- Adds runtime max/average mode, signed data, a configurable window size, and a line-accumulator buffer, so that a whole frame never needs to be held.

Parameters:
- IMG_W, 62, input frame width in pixels
- IMG_H, 65, input frame height in pixels
- CHANNELS, 32, channels per pixel
- BIT_WIDTH, 16, bits per channel sample
- POOL, 2, window size and stride. Legal values: 2 or 4.
- SIGNED, 1, 1 = two's-complement compare/sum; 0 = unsigned

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = max pool, 1 = average pool. Sampled on the first accepted beat of each frame.
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CHANNELS*BIT_WIDTH  one pixel; channel c occupies bits [c*BIT_WIDTH +: BIT_WIDTH]
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  CHANNELS*BIT_WIDTH  pooled pixel, same packing as in_data
- frame_done  out  1  single-cycle pulse on the cycle the last input beat of a frame is accepted

Behaviour:
- Reset (async assert, sync deassert inside block): out_valid=0, out_data=0, frame_done=0. Column/row counters=0. Mode latch=0. Accumulator contents are don't-care but flagged invalid. in_ready=1 one cycle after deassert.
- Output size is OW=IMG_W/POOL by OH=IMG_H/POOL (floor). Pixels with col>=OW*POOL or row>=OH*POOL are accepted and discarded. They still advance the counters and still count toward frame_done.
- Counters: col increments per accepted beat. It wraps at IMG_W-1 to 0 and increments row. Row wraps at IMG_H-1 to 0 (end of frame).
- Line accumulator: OW entries per channel, ACC_W = BIT_WIDTH + 2*log2(POOL) bits.
  - Max mode: the entry holds the running max, sign-extended per SIGNED.
  - Avg mode: the entry holds the running sum.
  - The first pixel of a window (col%POOL==0 and row%POOL==0) overwrites the entry; later pixels combine with it.
- Window completion: the beat with col%POOL==POOL-1 and row%POOL==POOL-1 inside the valid region. The combined result loads the output register on the following edge.
  - Max: the lower BIT_WIDTH bits of the max.
  - Avg: sum arithmetic-shifted right by 2*log2(POOL), i.e. floor. Signed or logical shift per SIGNED.
- Latency: 1 cycle from the completing input beat to out_valid.
- Output register holds one entry. out_data is stable while out_valid && !out_ready.
- in_ready = !out_valid || out_ready. It is held low even for non-completing beats while the output is stalled, which keeps the logic simple.
- A completing beat accepted while the output drains in the same cycle: the new value loads and out_valid stays 1.
- Mode toggled mid-frame: ignored until the next frame's first beat.
- Reset asserted mid-frame: the partial frame is discarded and any pending out_valid is dropped. The next beat after release is treated as pixel (0,0).
- Zero-length gaps (in_valid low) are allowed anywhere and have no effect on state.

Test Plan:
- IMG 4x4, CHANNELS=1, POOL=2, max, unsigned, pixels 0..15 raster, out_ready=1 -> outputs 5, 7, 13, 15, each 1 cycle after the beats at indices 5, 7, 13, 15. frame_done pulses with pixel 15.
- Same frame, mode=1 -> outputs 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5).
- IMG 5x5, max, pixels 0..24 -> 4 outputs: 6, 8, 16, 18. Column 4 and row 4 are discarded. frame_done on pixel 24.
- SIGNED=1, 2x2 window {-3, -1, -8, -2}: max -> -1 (0xFFFF). Avg -> sum -14, >>2 gives -4 (0xFFFC).
- Backpressure: out_ready low for 5 cycles after the first output -> out_data held constant, in_ready=0 throughout, no beat lost. The full frame matches the reference outputs after release.
- rst_n pulsed low after 6 beats of a 4x4 frame, then a full fresh frame -> out_valid=0 immediately on reset. Fresh frame outputs match scenario 1 exactly.
